// File: rtl/ram_bus_master_if.sv
// Request / write-data / read-response channels between a requester and ram_bus_master.
// Every channel uses one rule: a beat transfers on a rising CLK edge where valid && ready.
// valid must not depend on ready, and once valid is raised it holds, with stable payload,
// until that transfer happens.
interface ram_bus_master_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              wd_valid;
  logic              wd_ready;
  logic [31:0]       wd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_last;

  // Requester side.
  modport master (
    output req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rsp_ready,
    input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_last
  );

  // ram_bus_master side.
  modport slave (
    input  req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rsp_ready,
    output req_ready, wd_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/ram_bus_master.sv
// Bus master for a single-port 32-bit RAM with registered read and synchronous write.
// One burst (1..16 beats) is in flight at a time. The address wraps modulo 2^ADDR_W.
module ram_bus_master #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  ram_bus_master_if.slave   bus,
  output logic              busy,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [31:0]       DATA_BUS,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR      = 3'd2,
    RD_ADDR = 3'd3,
    RD_CAP  = 3'd4,
    RD_RSP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        beats_q, beats_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              cs_q, cs_d;
  logic              we_pin_q, we_pin_d;
  logic              req_ready_c;
  logic              wd_ready_c;

  // State, burst context and the registered RAM pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      cs_q       <= 1'b0;
      we_pin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      cs_q       <= cs_d;
      we_pin_q   <= we_pin_d;
    end
  end

  // Next-state, context update and handshake readies.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    req_ready_c = 1'b0;
    wd_ready_c  = 1'b0;
    cs_d        = 1'b0;
    we_pin_d    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          beats_d = bus.req_len;
          we_d    = bus.req_we;
          state_d = bus.req_we ? WR_DATA : RD_ADDR;
        end
      end
      WR_DATA: begin
        wd_ready_c = 1'b1;
        if (bus.wd_valid) begin
          wdata_d = bus.wd_data;
          state_d = WR;
        end
      end
      WR: begin
        // Accepting the next beat while this one is on the bus gives one beat per cycle.
        wd_ready_c = (beats_q != 4'd0);
        if (beats_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          beats_d = beats_q - 4'd1;
          if (bus.wd_valid) begin
            wdata_d = bus.wd_data;
            state_d = WR;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        // The RAM is driving the word it registered at the end of RD_ADDR.
        rsp_data_d = DATA_BUS;
        state_d    = RD_RSP;
      end
      RD_RSP: begin
        if (bus.rsp_ready) begin
          if (beats_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - 4'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pins are registered from the next state so they line up with the state they belong to.
    case (state_d)
      WR:      begin cs_d = 1'b1; we_pin_d = 1'b1; end
      RD_ADDR: begin cs_d = 1'b1; end
      RD_CAP:  begin cs_d = 1'b1; end
      default: begin cs_d = 1'b0; end
    endcase
  end

  // Readies are forced low while RST is held, even before the state register clears.
  assign bus.req_ready = req_ready_c && !RST;
  assign bus.wd_ready  = wd_ready_c && !RST;
  assign bus.rsp_valid = (state_q == RD_RSP);
  assign bus.rsp_last  = (state_q == RD_RSP) && (beats_q == 4'd0);
  assign bus.rsp_data  = rsp_data_q;

  assign busy        = (state_q != IDLE);
  assign CS          = cs_q;
  assign WE          = we_pin_q;
  assign ADDR        = addr_q;
  assign dbg_state_o = state_q;

  // The latched direction acts as a second guard so a read burst can never drive the bus.
  assign DATA_BUS = (cs_q && we_pin_q && we_q) ? wdata_q : {32{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a behavioural RAM on the shared bus, a word-array model of memory
// contents, and expected queues for RAM writes and read responses.
module tb_ram_bus_master;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              busy;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        dbg_state;
  wire  [31:0]       data_bus;

  ram_bus_master_if #(.ADDR_W(ADDR_W)) bus_if ();

  ram_bus_master #(.ADDR_W(ADDR_W)) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus_if),
    .busy        (busy),
    .CS          (cs),
    .WE          (we),
    .ADDR        (addr),
    .DATA_BUS    (data_bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural RAM on the shared bus ----------------
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ram_rd_q;
  logic        ram_rd_en_q;
  logic        ram_oe;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    ram_rd_q    = '0;
    ram_rd_en_q = 1'b0;
  end

  always @(posedge clk) begin
    if (cs && we) ram_mem[addr] <= data_bus;
    if (cs && !we) begin
      ram_rd_q    <= ram_mem[addr];
      ram_rd_en_q <= 1'b1;
    end else begin
      ram_rd_en_q <= 1'b0;
    end
  end

  assign ram_oe   = ram_rd_en_q && cs && !we;
  assign data_bus = ram_oe ? ram_rd_q : {32{1'bz}};

  // ---------------- reference model and scoreboard ----------------
  logic [31:0]          ref_mem [DEPTH];
  logic [ADDR_W+31:0]   wr_exp_q[$];   // {addr, data} of each RAM write expected, in order
  logic [32:0]          exp_q[$];      // {last, data} of each read response expected
  logic [31:0]          wd_src_q[$];   // fixed write data for directed bursts
  int                   n_cmp;
  int                   n_err;
  int                   wr_run;
  int                   wr_run_max;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    n_cmp = 0;
    n_err = 0;
    wr_run = 0;
    wr_run_max = 0;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Undriven bus: 'z in a four-state simulator, zero in a two-state one.
  logic bus_free;
  assign bus_free = $isunknown(data_bus) || (data_bus == 32'd0);

  // Per-cycle monitor: RAM writes, bus ownership and read responses.
  always @(negedge clk) begin
    if (!rst) begin
      if (cs && we) begin
        wr_run++;
        if (wr_run > wr_run_max) wr_run_max = wr_run;
        if (wr_exp_q.size() == 0) begin
          check_val("wr_extra", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          logic [ADDR_W+31:0] e;
          e = wr_exp_q.pop_front();
          check_val("wr_addr", 32'(addr), 32'(e[ADDR_W+31:32]));
          check_val("wr_data", data_bus, e[31:0]);
        end
      end else begin
        wr_run = 0;
        if (!ram_oe) check_val("bus_free", 32'(bus_free), 32'd1);
      end
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_extra", bus_if.rsp_data, 32'hFFFF_FFFF);
        end else begin
          logic [32:0] r;
          r = exp_q.pop_front();
          check_val("rsp_data", bus_if.rsp_data, r[31:0]);
          check_val("rsp_last", 32'(bus_if.rsp_last), 32'(r[32]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [3:0] len);
    int cnt;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = wr;
    bus_if.req_addr  = a;
    bus_if.req_len   = len;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus_if.req_ready && cnt < 50);
    if (!bus_if.req_ready) check_val("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 50);
    if (busy) check_val("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Write burst of n beats; before beat gap_beat the data source idles for gap_cyc cycles.
  task automatic wr_burst(input logic [ADDR_W-1:0] a, input int n, input int gap_beat,
                          input int gap_cyc);
    logic [31:0] d [$];
    for (int i = 0; i < n; i++) begin
      logic [31:0]       v;
      logic [ADDR_W-1:0] wa;
      v  = (wd_src_q.size() != 0) ? wd_src_q.pop_front() : ($urandom() | 32'h1);
      wa = ADDR_W'((int'(a) + i) % DEPTH);
      ref_mem[wa] = v;
      wr_exp_q.push_back({wa, v});
      d.push_back(v);
    end
    wr_run_max = 0;
    send_req(1'b1, a, 4'(n - 1));
    for (int i = 0; i < n; i++) begin
      int cnt;
      if (i == gap_beat) begin
        bus_if.wd_valid = 1'b0;
        for (int k = 0; k < gap_cyc; k++) begin
          @(negedge clk);
          if (k > 0) begin
            check_val("gap_cs", 32'(cs), 32'd0);
            check_val("gap_wd_ready", 32'(bus_if.wd_ready), 32'd1);
          end
          @(posedge clk); #1;
        end
      end
      bus_if.wd_valid = 1'b1;
      bus_if.wd_data  = d[i];
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus_if.wd_ready && cnt < 50);
      if (!bus_if.wd_ready) check_val("wd_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    bus_if.wd_valid = 1'b0;
    wait_idle();
  endtask

  // Read burst of n beats; beat stall_beat sees rsp_ready low for stall_cyc cycles.
  // When abort_beat matches, RST is applied while that beat waits instead.
  task automatic rd_burst(input logic [ADDR_W-1:0] a, input int n, input int stall_beat,
                          input int stall_cyc, input int abort_beat);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'(i == n - 1), ref_mem[(int'(a) + i) % DEPTH]});
    end
    bus_if.rsp_ready = (stall_beat != 0) && (abort_beat != 0);
    send_req(1'b0, a, 4'(n - 1));
    for (int i = 0; i < n; i++) begin
      int          cnt;
      logic [31:0] held;
      bus_if.rsp_ready = (i != stall_beat) && (i != abort_beat);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus_if.rsp_valid && cnt < 50);
      check_val("rd_latency", 32'(cnt), 32'd3);
      if (i == abort_beat) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_cs", 32'(cs), 32'd0);
        check_val("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        check_val("rst_rsp_data", bus_if.rsp_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        exp_q.delete();
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (i == stall_beat) begin
        held = bus_if.rsp_data;
        for (int k = 1; k < stall_cyc; k++) begin
          @(negedge clk);
          check_val("stall_valid", 32'(bus_if.rsp_valid), 32'd1);
          check_val("stall_data", bus_if.rsp_data, held);
          check_val("stall_cs", 32'(cs), 32'd0);
        end
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_len   = '0;
    bus_if.wd_valid  = 1'b0;
    bus_if.wd_data   = '0;
    bus_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_cs", 32'(cs), 32'd0);
    check_val("reset_we", 32'(we), 32'd0);
    check_val("reset_addr", 32'(addr), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_req_ready", 32'(bus_if.req_ready), 32'd0);
    check_val("reset_wd_ready", 32'(bus_if.wd_ready), 32'd0);
    check_val("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_val("reset_rsp_data", bus_if.rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("first_req_ready", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk); #1;

    // Single write then single read.
    wd_src_q.push_back(32'hDEAD_BEEF);
    wr_burst(6'd5, 1, -1, 0);
    check_val("single_wr_cycles", 32'(wr_run_max), 32'd1);
    rd_burst(6'd5, 1, -1, 0, -1);

    // Four-beat burst with data always ready, then read back.
    for (int i = 1; i <= 4; i++) wd_src_q.push_back(32'(i));
    wr_burst(6'd10, 4, -1, 0);
    check_val("burst_wr_run", 32'(wr_run_max), 32'd4);
    rd_burst(6'd10, 4, -1, 0, -1);

    // Address wrap at the top of the space.
    wd_src_q.push_back(32'hAAAA_0001);
    wd_src_q.push_back(32'hBBBB_0002);
    wd_src_q.push_back(32'hCCCC_0003);
    wr_burst(6'd62, 3, -1, 0);
    rd_burst(6'd0, 1, -1, 0, -1);
    rd_burst(6'd62, 3, -1, 0, -1);

    // Backpressure on both channels.
    rd_burst(6'd10, 2, 0, 5, -1);
    wr_burst(6'd20, 4, 2, 4);
    rd_burst(6'd20, 4, 3, 2, -1);

    // Randomized bursts.
    for (int it = 0; it < 24; it++) begin
      logic [ADDR_W-1:0] a;
      int                n;
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        wr_burst(a, n, (n > 1) ? $urandom_range(1, n - 1) : -1, $urandom_range(2, 4));
      end else begin
        rd_burst(a, n, $urandom_range(0, n - 1), $urandom_range(1, 4), -1);
      end
    end

    // Reset during the second beat of an eight-beat read, then a fresh single read.
    rd_burst(6'd10, 8, -1, 0, 1);
    rd_burst(6'd11, 1, -1, 0, -1);

    check_val("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    check_val("rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
